// File: rtl/mem_wb_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Combined MEM stage and MEM/WB pipeline register. Performs loads and stores
// against an internal word array and registers the writeback triple
// (Result_WB, writeBackEn, Dest_wb) consumed by the ID-stage register file.
// Memory accesses take MEM_LATENCY extra cycles, during which `ready` is low
// and the upstream pipeline holds its inputs stable.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   WB_EN_IN     instruction writes a register
//   MEM_R_EN_IN  load
//   MEM_W_EN_IN  store (wins over load when both are set)
//   ALU_Result   EXE result; byte address for loads/stores
//   Val_Rm       store data
//   Dest_IN      destination register index
//   ready        0 = MEM busy, upstream must freeze
//   Result_WB    writeback data
//   writeBackEn  register-file write enable (one cycle per instruction)
//   Dest_wb      register-file write index
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Val_Rm,
  input  logic [3:0]  Dest_IN,
  output logic        ready,
  output logic [31:0] Result_WB,
  output logic        writeBackEn,
  output logic [3:0]  Dest_wb
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam bit HAS_WAIT = (MEM_LATENCY > 0);
  // Counter preload: the first wait cycle is spent in IDLE, so WAIT counts
  // down from MEM_LATENCY-1 and completes when the counter reaches zero.
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic             wb_en_q, wb_en_d;
  logic [3:0]       dest_q, dest_d;

  logic [31:0]      mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic             mem_op;
  logic             is_load;
  logic             below_base;
  logic [31:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rdata;
  logic             mem_we;

  always_comb begin
    mem_op     = MEM_R_EN_IN | MEM_W_EN_IN;
    // A combined read/write request is treated as a store; its result is
    // the ALU value, not memory data.
    is_load    = MEM_R_EN_IN & ~MEM_W_EN_IN;
    below_base = (ALU_Result < BASE_ADDR);
    // Byte offset to word offset; the two low address bits are dropped.
    word_off   = (ALU_Result - BASE_ADDR) >> 2;
    in_range   = !below_base && (word_off < 32'(DEPTH_WORDS));
    word_idx   = word_off[IDX_W-1:0];
    rdata      = in_range ? mem[word_idx] : 32'd0;
  end

  // ---------------------------------------------------------------------------
  // Handshake: ready drops for the first MEM_LATENCY cycles of an access.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b1;
    if (state_q == S_IDLE && mem_op && HAS_WAIT) begin
      ready = 1'b0;
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      ready = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait-state sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps latches from being inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op && HAS_WAIT) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Completion edge; a following op starts fresh from IDLE.
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register next values
  // ---------------------------------------------------------------------------
  always_comb begin
    result_d = result_q;
    dest_d   = dest_q;
    wb_en_d  = 1'b0;  // stall edges insert a bubble
    if (ready) begin
      wb_en_d  = WB_EN_IN;
      dest_d   = Dest_IN;
      // rdata is sampled before the edge, so a load sees pre-write contents.
      result_d = is_load ? rdata : ALU_Result;
    end
  end

  // Stores commit only on the completion edge, so an access interrupted by
  // reset leaves memory untouched.
  assign mem_we = ready && MEM_W_EN_IN && in_range && !rst;

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= 32'd0;
      wb_en_q  <= 1'b0;
      dest_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      wb_en_q  <= wb_en_d;
      dest_q   <= dest_d;
    end
  end

  // NOTE: the data array has no reset; contents survive rst, and leaving the
  // reset out lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= Val_Rm;
    end
  end

  assign Result_WB   = result_q;
  assign writeBackEn = wb_en_q;
  assign Dest_wb     = dest_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Drives two instances of mem_wb_stage (MEM_LATENCY = 2 and 0) with directed
// and random instructions. Expected writebacks come from a word-array model
// and are queued at issue time; monitors pop them whenever writeBackEn is
// seen. The driver also checks how many cycles ready stays low per access.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Slow instance (MEM_LATENCY = 2)
  logic        s_wb, s_r, s_w;
  logic [31:0] s_alu, s_val;
  logic [3:0]  s_dest;
  logic        s_ready, s_wben;
  logic [31:0] s_res;
  logic [3:0]  s_dst;

  // Fast instance (MEM_LATENCY = 0)
  logic        f_wb, f_r, f_w;
  logic [31:0] f_alu, f_val;
  logic [3:0]  f_dest;
  logic        f_ready, f_wben;
  logic [31:0] f_res;
  logic [3:0]  f_dst;

  mem_wb_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(2), .BASE_ADDR(BASE)) u_slow (
    .clk(clk), .rst(rst),
    .WB_EN_IN(s_wb), .MEM_R_EN_IN(s_r), .MEM_W_EN_IN(s_w),
    .ALU_Result(s_alu), .Val_Rm(s_val), .Dest_IN(s_dest),
    .ready(s_ready), .Result_WB(s_res), .writeBackEn(s_wben), .Dest_wb(s_dst)
  );

  mem_wb_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(0), .BASE_ADDR(BASE)) u_fast (
    .clk(clk), .rst(rst),
    .WB_EN_IN(f_wb), .MEM_R_EN_IN(f_r), .MEM_W_EN_IN(f_w),
    .ALU_Result(f_alu), .Val_Rm(f_val), .Dest_IN(f_dest),
    .ready(f_ready), .Result_WB(f_res), .writeBackEn(f_wben), .Dest_wb(f_dst)
  );

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] result;
  } exp_t;

  exp_t        q_s[$];
  exp_t        q_f[$];
  logic [31:0] mdl_s [DEPTH];
  logic [31:0] mdl_f [DEPTH];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'($urandom_range(0, 1023));
    if (sel == 1) return 32'd1280 + 32'($urandom_range(0, 4000));
    return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: every writeBackEn pulse must match the oldest queued expectation.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : mon_slow
    exp_t e;
    if (!rst && s_wben) begin
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL slow_unexpected_wb: got dest %0d result %h expected no writeback", s_dst, s_res);
      end else begin
        e = q_s.pop_front();
        check("slow_dest", 32'(s_dst), 32'(e.dest));
        check("slow_result", s_res, e.result);
      end
    end
  end

  always @(negedge clk) begin : mon_fast
    exp_t e;
    if (!rst && f_wben) begin
      if (q_f.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fast_unexpected_wb: got dest %0d result %h expected no writeback", f_dst, f_res);
      end else begin
        e = q_f.pop_front();
        check("fast_dest", 32'(f_dst), 32'(e.dest));
        check("fast_result", f_res, e.result);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: present one instruction at a negedge, hold it until accepted.
  // ---------------------------------------------------------------------------
  task automatic set_inputs(input bit slow, input logic wb, input logic r, input logic w,
                            input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
    if (slow) begin
      s_wb = wb; s_r = r; s_w = w; s_alu = alu; s_val = val; s_dest = dest;
    end else begin
      f_wb = wb; f_r = r; f_w = w; f_alu = alu; f_val = val; f_dest = dest;
    end
  endtask

  task automatic issue(input bit slow, input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
    exp_t        e;
    logic [31:0] word;
    int          low;
    int          lat_exp;
    bit          rdy;

    set_inputs(slow, wb, r, w, alu, val, dest);

    word = 32'd0;
    if (addr_ok(alu)) word = slow ? mdl_s[addr_idx(alu)] : mdl_f[addr_idx(alu)];
    e.dest   = dest;
    e.result = (r && !w) ? word : alu;
    if (wb) begin
      if (slow) q_s.push_back(e);
      else      q_f.push_back(e);
    end
    lat_exp = (r || w) ? (slow ? 2 : 0) : 0;

    low = 0;
    #1;
    rdy = slow ? s_ready : f_ready;
    while (!rdy && low < 20) begin
      low++;
      @(negedge clk);
      #1;
      rdy = slow ? s_ready : f_ready;
    end
    check(slow ? "slow_ready_low_cycles" : "fast_ready_low_cycles", 32'(low), 32'(lat_exp));

    @(posedge clk);
    if (w && addr_ok(alu)) begin
      if (slow) mdl_s[addr_idx(alu)] = val;
      else      mdl_f[addr_idx(alu)] = val;
    end
    @(negedge clk);
    set_inputs(slow, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic run_suite(input bit slow);
    logic [31:0] alu;
    logic [31:0] val;
    int unsigned kind;

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < DEPTH; i++) begin
      issue(slow, 1'b0, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom | 32'h1000_0000, 4'd0);
    end

    // ALU pass-through
    issue(slow, 1'b1, 1'b0, 1'b0, 32'h12, 32'd0, 4'd3);
    // Store then load of the same word
    issue(slow, 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0);
    issue(slow, 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5);
    // Single-cycle style store/load to 1036, back to back
    issue(slow, 1'b0, 1'b0, 1'b1, 32'd1036, 32'hCAFE_0036, 4'd0);
    issue(slow, 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd9);
    // Out-of-range store just past the end, out-of-range load just below base
    issue(slow, 1'b0, 1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'hBAD0_BAD0, 4'd0);
    issue(slow, 1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd6);
    // Last word with unaligned low bits; combined read+write returns ALU value
    issue(slow, 1'b1, 1'b1, 1'b0, BASE + 32'(4 * DEPTH - 1), 32'd0, 4'd2);
    issue(slow, 1'b1, 1'b1, 1'b1, 32'd1040, 32'h0000_7777, 4'd4);
    issue(slow, 1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd8);

    // Random mix
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      alu  = (kind == 0) ? $urandom : rand_addr();
      val  = $urandom;
      issue(slow, 1'($urandom_range(0, 1)), kind == 1 || kind == 3, kind >= 2,
            alu, val, 4'($urandom_range(0, 15)));
    end

    // Read every word back
    for (int i = 0; i < DEPTH; i++) begin
      issue(slow, 1'b1, 1'b1, 1'b0, BASE + 32'(4 * i), 32'd0, 4'(i));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset with the clock stopped: outputs clear immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_slow_result", s_res, 32'd0);
    check("rst_slow_wben", 32'(s_wben), 32'd0);
    check("rst_slow_dest", 32'(s_dst), 32'd0);
    check("rst_slow_ready", 32'(s_ready), 32'd1);
    check("rst_fast_result", f_res, 32'd0);
    check("rst_fast_wben", 32'(f_wben), 32'd0);
    check("rst_fast_dest", 32'(f_dst), 32'd0);
    check("rst_fast_ready", 32'(f_ready), 32'd1);

    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_suite(1'b1);
    run_suite(1'b0);

    // Reset during the wait of a store: the store must be abandoned.
    set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 32'd1032, 32'h0000_0055, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    check("midrst_wben", 32'(s_wben), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd7);

    repeat (3) @(negedge clk);
    check("slow_queue_drained", 32'(q_s.size()), 32'd0);
    check("fast_queue_drained", 32'(q_f.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
